// File: rtl/stream_cipher_pkg.sv
// Shared types and widths for the stream-cipher datapath.
package stream_cipher_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned COUNT_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitHash,
        StOut
    } enc_state_t;

endpackage

// File: rtl/hash_watchdog.sv
// Counts consecutive hash-wait cycles; flags a timeout (sticky) and asks for a re-request.
// Instantiated by stream_encryptor only when STREAM_CIPHER_HASH_WATCHDOG_EN is defined.
module hash_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_wait_i,
    input  logic pulse_i,
    output logic expire_o,
    output logic timeout_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    // The current wait cycle is the TIMEOUT_CYCLES-th one without a hash.
    assign expire_o  = in_wait_i && !pulse_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign timeout_o = timeout_q;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (!in_wait_i || pulse_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (expire_o) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: rtl/stream_encryptor.sv
// XORs each plaintext byte with one requested keystream byte and counts delivered bytes.
// Optional hash watchdog enabled by defining STREAM_CIPHER_HASH_WATCHDOG_EN.
module stream_encryptor
    import stream_cipher_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_W-1:0]  pt_byte,
    input  logic               pt_valid,
    output logic               pt_ready,
    output logic               request_hash_byte_pulse,
    input  logic [BYTE_W-1:0]  hash_byte,
    input  logic               hash_byte_pulse,
    output logic [BYTE_W-1:0]  ct_byte,
    output logic               ct_valid,
    input  logic               ct_ready,
    output logic [COUNT_W-1:0] byte_count,
    output logic               hash_timeout
);

    enc_state_t         state_q, state_d;
    logic [BYTE_W-1:0]  pt_q, pt_d;
    logic [BYTE_W-1:0]  ct_q, ct_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               rdy_en_q;
    logic               expire;

`ifdef STREAM_CIPHER_HASH_WATCHDOG_EN
    logic in_wait;
    assign in_wait = (state_q == StWaitHash);

    hash_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_hash_watchdog (
        .clk_i    (clk),
        .rst_i    (rst),
        .in_wait_i(in_wait),
        .pulse_i  (hash_byte_pulse),
        .expire_o (expire),
        .timeout_o(hash_timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign expire             = 1'b0;
    assign hash_timeout       = 1'b0;
`endif

    // Registered so pt_ready stays low while rst is held, without a combinational path from rst.
    assign pt_ready                = rdy_en_q && (state_q == StIdle);
    assign request_hash_byte_pulse = (state_q == StReq);
    assign ct_valid                = (state_q == StOut);
    assign ct_byte                 = ct_q;
    assign byte_count              = cnt_q;

    always_comb begin
        state_d = state_q;
        pt_d    = pt_q;
        ct_d    = ct_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pt_valid && rdy_en_q) begin
                    pt_d    = pt_byte;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (hash_byte_pulse) begin
                    ct_d    = pt_q ^ hash_byte;
                    state_d = StOut;
                end else begin
                    state_d = StWaitHash;
                end
            end
            StWaitHash: begin
                if (hash_byte_pulse) begin
                    ct_d    = pt_q ^ hash_byte;
                    state_d = StOut;
                end else if (expire) begin
                    state_d = StReq;
                end
            end
            StOut: begin
                if (ct_ready) begin
                    cnt_d   = cnt_q + COUNT_W'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pt_q     <= '0;
            ct_q     <= '0;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pt_q     <= pt_d;
            ct_q     <= ct_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule
